// File: rtl/framebuffer_vga.sv
// framebuffer_vga
//   VGA framebuffer controller: pixel-strobe divider, 640x400 timing
//   generator, WIDTH x HEIGHT x BPP pixel memory, host write port with
//   backpressure, full-frame clear engine and a two-strobe scan-out
//   pipeline whose syncs stay aligned with the pixel data.
//   The timing parameters default to 640x400 @ 25 MHz pixel rate.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   wr_valid/wr_ready, wr_x, wr_y, wr_color
//                host pixel write; out-of-range coordinates are accepted and dropped
//   clr_start    one-cycle pulse, fills the framebuffer with clr_color
//   clr_color    fill value, sampled when clr_start is accepted
//   clr_busy     clear engine active (host writes are held off)
//   frame_start  one-clk pulse on the strobe of line 0, pixel 0
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active high
//   VGA_R/G/B    3/3/2-bit colour, black outside the framebuffer region
module framebuffer_vga #(
  parameter int WIDTH        = 200,
  parameter int HEIGHT       = 160,
  parameter int BPP          = 1,
  parameter int SCALE_LOG2   = 1,
  parameter int PIX_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 400,
  parameter int V_SYNC_START = 412,
  parameter int V_SYNC_END   = 414,
  parameter int V_TOTAL      = 449
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [9:0]     wr_x,
  input  logic [8:0]     wr_y,
  input  logic [BPP-1:0] wr_color,
  input  logic           clr_start,
  input  logic [BPP-1:0] clr_color,
  output logic           clr_busy,
  output logic           frame_start,
  output logic           hsync,
  output logic           vsync,
  output logic [2:0]     VGA_R,
  output logic [2:0]     VGA_G,
  output logic [1:0]     VGA_B
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]    H_SS      = 10'(H_SYNC_START);
  localparam logic [9:0]    H_SE      = 10'(H_SYNC_END);
  localparam logic [8:0]    V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0]    V_ACT     = 9'(V_ACTIVE);
  localparam logic [8:0]    V_SS      = 9'(V_SYNC_START);
  localparam logic [8:0]    V_SE      = 9'(V_SYNC_END);
  localparam logic [9:0]    FB_W_LIM  = 10'(WIDTH);
  localparam logic [8:0]    FB_H_LIM  = 9'(HEIGHT);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX - 1);

  // ---------------------------------------------------------------
  // Pixel strobe divider and timing counters
  // ---------------------------------------------------------------
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [8:0]    v_cnt_q, v_cnt_d;
  logic          strobe, strobe_d;
  logic          frame_start_q;
  logic          ready_q;

  assign strobe = (div_q == DIV_LAST);

  always_comb begin
    div_d   = strobe ? '0 : div_q + DW'(1);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (strobe) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 9'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Look one clk ahead so frame_start can be a register yet still
  // coincide with the strobe at h=0, v=0.
  assign strobe_d = (div_d == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= strobe_d && (h_cnt_d == '0) && (v_cnt_d == '0);
      ready_q       <= 1'b1;
    end
  end

  assign frame_start = frame_start_q;

  // ---------------------------------------------------------------
  // Clear engine: IDLE -> CLEAR (one word per clk) -> IDLE
  // ---------------------------------------------------------------
  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t     state_q;
  logic [AW-1:0]  clr_addr_q;
  logic [BPP-1:0] clr_color_q;
  logic           clr_busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            clr_color_q <= clr_color;
            clr_busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr_q == ADDR_LAST) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_q;
  // ready_q keeps the port closed while reset is held and for the release cycle.
  assign wr_ready = ready_q && !clr_busy_q;

  // ---------------------------------------------------------------
  // Pixel memory write port (clear engine has priority; host is
  // already stalled by wr_ready while clearing)
  // ---------------------------------------------------------------
  logic           host_fire;
  logic           host_in_range;
  logic [AW-1:0]  host_addr;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [BPP-1:0] mem_wdata;

  assign host_fire     = wr_valid && wr_ready;
  assign host_in_range = (wr_x < FB_W_LIM) && (wr_y < FB_H_LIM);
  assign host_addr     = AW'(32'(wr_y) * WIDTH + 32'(wr_x));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = wr_color;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = clr_color_q;
    end else if (host_fire && host_in_range) begin
      mem_we = 1'b1;
    end
  end

  logic [BPP-1:0] fb_mem [NPIX];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      fb_mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------
  // Scan-out: S1 = address + flags, S2 = RAM data + flags
  // ---------------------------------------------------------------
  logic [9:0]    fx;
  logic [8:0]    fy;
  logic          in_active;
  logic          in_fb;
  logic          hs_raw;
  logic          vs_raw;
  logic [AW-1:0] addr_q;
  logic          inside1_q, inside2_q;
  logic          hs1_q, hs2_q;
  logic          vs1_q, vs2_q;
  logic [BPP-1:0] rd_data_q;

  assign fx        = h_cnt_q >> SCALE_LOG2;
  assign fy        = v_cnt_q >> SCALE_LOG2;
  assign in_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign in_fb     = (fx < FB_W_LIM) && (fy < FB_H_LIM);
  assign hs_raw    = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
  assign vs_raw    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      inside1_q <= 1'b0;
      inside2_q <= 1'b0;
      hs1_q     <= 1'b1;
      hs2_q     <= 1'b1;
      vs1_q     <= 1'b0;
      vs2_q     <= 1'b0;
    end else if (strobe) begin
      // Park the address at 0 outside the region so it never leaves the array.
      addr_q    <= (in_active && in_fb) ? AW'(32'(fy) * WIDTH + 32'(fx)) : '0;
      inside1_q <= in_active && in_fb;
      hs1_q     <= hs_raw;
      vs1_q     <= vs_raw;
      inside2_q <= inside1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
    end
  end

  // Block-RAM read register; no reset, the output is gated by inside2_q.
  always_ff @(posedge clk) begin
    if (strobe) begin
      rd_data_q <= fb_mem[addr_q];
    end
  end

  // ---------------------------------------------------------------
  // Colour mapping
  // ---------------------------------------------------------------
  logic [7:0] rgb;
  genvar gi;

  generate
    if (BPP == 1) begin : g_mono
      for (gi = 0; gi < 8; gi++) begin : g_bit
        assign rgb[gi] = inside2_q & rd_data_q[0];
      end
    end else begin : g_rgb332
      assign rgb = inside2_q ? rd_data_q[7:0] : 8'd0;
    end
  endgenerate

  assign hsync = hs2_q;
  assign vsync = vs2_q;
  assign VGA_R = rgb[7:5];
  assign VGA_G = rgb[4:2];
  assign VGA_B = rgb[1:0];

endmodule

// File: tb/tb_framebuffer_vga.sv
// Directed bench for framebuffer_vga. Two instances share all stimulus:
// dut_a is 1 bpp (fed wr_color[0]), dut_b is 8 bpp RGB332. Both use an
// 8x6 framebuffer at scale 2 and a shrunk 32x20-strobe raster so whole
// frames fit in a short run:
//   h: active 0-23, hsync low 26-29, total 32
//   v: active 0-15, vsync high 17-18, total 20
// Framebuffer region on screen: h 0-15, v 0-11.
module tb_framebuffer_vga;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int PD    = 4;
  localparam int HT    = 32;
  localparam int VT    = 20;
  localparam int NPIX  = W * H;
  localparam int FRAME = HT * VT;
  localparam logic [12:0] RST_OUT = 13'h200;  // only hsync high

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [7:0] wr_color;
  logic       clr_start;
  logic [7:0] clr_color;

  logic       wr_ready_a, clr_busy_a, frame_start_a, hsync_a, vsync_a;
  logic [2:0] VGA_R_a, VGA_G_a;
  logic [1:0] VGA_B_a;
  logic       wr_ready_b, clr_busy_b, frame_start_b, hsync_b, vsync_b;
  logic [2:0] VGA_R_b, VGA_G_b;
  logic [1:0] VGA_B_b;

  logic [12:0] outs_a, outs_b;
  assign outs_a = {wr_ready_a, clr_busy_a, frame_start_a, hsync_a, vsync_a, VGA_R_a, VGA_G_a, VGA_B_a};
  assign outs_b = {wr_ready_b, clr_busy_b, frame_start_b, hsync_b, vsync_b, VGA_R_b, VGA_G_b, VGA_B_b};

  logic [7:0] model [NPIX];
  int checks   = 0;
  int failures = 0;
  int w;

  always #5 clk = ~clk;

  framebuffer_vga #(
    .WIDTH(W), .HEIGHT(H), .BPP(1), .SCALE_LOG2(1), .PIX_DIV(PD),
    .H_ACTIVE(24), .H_SYNC_START(26), .H_SYNC_END(30), .H_TOTAL(HT),
    .V_ACTIVE(16), .V_SYNC_START(17), .V_SYNC_END(19), .V_TOTAL(VT)
  ) dut_a (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready_a),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color[0:0]),
    .clr_start(clr_start), .clr_color(clr_color[0:0]), .clr_busy(clr_busy_a),
    .frame_start(frame_start_a), .hsync(hsync_a), .vsync(vsync_a),
    .VGA_R(VGA_R_a), .VGA_G(VGA_G_a), .VGA_B(VGA_B_a)
  );

  framebuffer_vga #(
    .WIDTH(W), .HEIGHT(H), .BPP(8), .SCALE_LOG2(1), .PIX_DIV(PD),
    .H_ACTIVE(24), .H_SYNC_START(26), .H_SYNC_END(30), .H_TOTAL(HT),
    .V_ACTIVE(16), .V_SYNC_START(17), .V_SYNC_END(19), .V_TOTAL(VT)
  ) dut_b (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready_b),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy_b),
    .frame_start(frame_start_b), .hsync(hsync_b), .vsync(vsync_b),
    .VGA_R(VGA_R_b), .VGA_G(VGA_G_b), .VGA_B(VGA_B_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected {hsync, vsync, RGB} for raster position q (strobe index in frame).
  function automatic logic [9:0] exp_scan(input int q, input bit mono);
    int h, v;
    bit hs, vs, ins;
    logic [7:0] p;
    h   = q % HT;
    v   = q / HT;
    hs  = !(h >= 26 && h < 30);
    vs  = (v >= 17 && v < 19);
    ins = (h < 24) && (v < 16) && ((h >> 1) < W) && ((v >> 1) < H);
    p   = 8'd0;
    if (ins) begin
      p = model[(v >> 1) * W + (h >> 1)];
      if (mono) p = {8{p[0]}};
    end
    return {hs, vs, p};
  endfunction

  // Called right after reset is released on a falling edge.
  task automatic release_check(input string tag);
    logic [2:0] fs_a, fs_b;
    @(negedge clk);
    check({tag, "_rdy"}, 32'({wr_ready_a, wr_ready_b, clr_busy_a, clr_busy_b}), 32'b1100);
    fs_a[2] = frame_start_a; fs_b[2] = frame_start_b;
    @(negedge clk);
    fs_a[1] = frame_start_a; fs_b[1] = frame_start_b;
    @(negedge clk);
    fs_a[0] = frame_start_a; fs_b[0] = frame_start_b;
    // Divider runs 0,1,2,3 from release: first strobe is the fourth clk.
    check({tag, "_fs_a"}, 32'(fs_a), 32'b001);
    check({tag, "_fs_b"}, 32'(fs_b), 32'b001);
  endtask

  task automatic write_px(input int x, input int y, input logic [7:0] c, output int waits);
    waits    = 0;
    wr_x     = 10'(x);
    wr_y     = 9'(y);
    wr_color = c;
    wr_valid = 1'b1;
    while (!wr_ready_b && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!wr_ready_b) begin
      check("wr_timeout", 32'(wr_ready_b), 32'd1);
      wr_valid = 1'b0;
      return;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    $display("write x=%0d y=%0d c=0x%02h waits=%0d", x, y, c, waits);
    if (x < W && y < H) model[y * W + x] = c;
  endtask

  // busy_traffic: host write issued together with clr_start, a second
  // write held during the clear, and a stray clr_start mid-clear.
  task automatic clear_frame(input logic [7:0] color, input bit busy_traffic);
    int busy;
    clr_start = 1'b1;
    clr_color = color;
    if (busy_traffic) begin
      wr_valid = 1'b1; wr_x = 10'd1; wr_y = 9'd1; wr_color = 8'h11;
    end
    @(negedge clk);
    clr_start = 1'b0;
    if (busy_traffic) begin
      wr_x = 10'd2; wr_y = 9'd1; wr_color = 8'h55;
    end
    busy = 0;
    while (clr_busy_b && busy < 200) begin
      busy++;
      check("rdy_in_clr", 32'({wr_ready_a, wr_ready_b}), 32'b00);
      if (busy_traffic && busy == 20) begin
        clr_start = 1'b1;
        clr_color = 8'h00;
      end else begin
        clr_start = 1'b0;
      end
      @(negedge clk);
    end
    clr_start = 1'b0;
    $display("clear color=0x%02h busy_clks=%0d", color, busy);
    check("clr_len", 32'(busy), 32'(NPIX));
    check("rdy_after_clr", 32'({wr_ready_a, wr_ready_b, clr_busy_a, clr_busy_b}), 32'b1100);
    for (int i = 0; i < NPIX; i++) model[i] = color;
    if (busy_traffic) begin
      @(negedge clk);
      wr_valid = 1'b0;
      model[1 * W + 2] = 8'h55;
      check("no_restart", 32'({clr_busy_a, clr_busy_b}), 32'b00);
    end
  endtask

  task automatic scan_frame(input string tag);
    int n, q, errs;
    n = 0;
    errs = failures;
    while (!frame_start_b && n < 3 * FRAME * PD) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_fs_seen"}, 32'(frame_start_b), 32'd1);
    if (!frame_start_b) return;
    for (int cyc = 1; cyc <= (FRAME + 2) * PD; cyc++) begin
      @(negedge clk);
      if (cyc == FRAME * PD - PD)
        check({tag, "_fs_gap"}, 32'({frame_start_a, frame_start_b}), 32'b00);
      if (cyc == FRAME * PD)
        check({tag, "_fs_period"}, 32'({frame_start_a, frame_start_b}), 32'b11);
      if (cyc % PD == 0 && cyc / PD >= 2) begin
        q = (cyc / PD - 2) % FRAME;
        check($sformatf("%s_px h=%0d v=%0d", tag, q % HT, q / HT),
              32'({hsync_a, vsync_a, VGA_R_a, VGA_G_a, VGA_B_a,
                   hsync_b, vsync_b, VGA_R_b, VGA_G_b, VGA_B_b}),
              32'({exp_scan(q, 1'b1), exp_scan(q, 1'b0)}));
      end
    end
    $display("scan %s frame checked, new_failures=%0d", tag, failures - errs);
  endtask

  initial begin
    reset     = 1'b0;
    wr_valid  = 1'b0;
    wr_x      = '0;
    wr_y      = '0;
    wr_color  = '0;
    clr_start = 1'b0;
    clr_color = '0;
    repeat (3) @(negedge clk);
    check("rst_a", 32'(outs_a), 32'(RST_OUT));
    check("rst_b", 32'(outs_b), 32'(RST_OUT));
    reset = 1'b1;
    release_check("rel0");

    clear_frame(8'h00, 1'b0);

    write_px(0, 0, 8'h25, w);
    write_px(7, 5, 8'h93, w);
    write_px(3, 2, 8'h4C, w);
    write_px(8, 0, 8'hFF, w);
    check("oob_x_ready", 32'(w), 32'd0);
    write_px(0, 6, 8'hFF, w);
    check("oob_y_ready", 32'(w), 32'd0);
    write_px(9, 5, 8'hFF, w);
    check("oob_xy_ready", 32'(w), 32'd0);
    scan_frame("f1");

    clear_frame(8'hE3, 1'b1);
    scan_frame("f2");

    // Reset in the middle of a clear.
    clr_start = 1'b1;
    clr_color = 8'h00;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_mid", 32'({clr_busy_a, clr_busy_b}), 32'b11);
    #2 reset = 1'b0;
    #1;
    check("rst_async_a", 32'(outs_a), 32'(RST_OUT));
    check("rst_async_b", 32'(outs_b), 32'(RST_OUT));
    @(negedge clk);
    reset = 1'b1;
    release_check("rel1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
